// File: rtl/core_regfile.sv
// i2d general-purpose register file: one writeback port, two bypassed read ports,
// and a pending-write scoreboard that raises a RAW stall toward ID.
module core_regfile #(
  parameter int NREGS = 16,
  parameter int DW    = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb,
  input  logic [AW-1:0]    wb_addr,
  input  logic [DW-1:0]    wb_data,
  input  logic             rda_en,
  input  logic [AW-1:0]    rda_addr,
  output logic [DW-1:0]    rega_data,
  input  logic             rdb_en,
  input  logic [AW-1:0]    rdb_addr,
  output logic [DW-1:0]    regb_data,
  input  logic             iss_valid,
  input  logic             iss_wb,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  output logic             id_stall,
  output logic [NREGS-1:0] pending
);

  logic [NREGS-1:0][DW-1:0] regs_q, regs_d;
  logic [NREGS-1:0]         pend_q, pend_d;
  logic                     wb_hit_a, wb_hit_b, hit_a, hit_b, iss_set;

  assign wb_hit_a  = wb && (wb_addr == rda_addr);
  assign wb_hit_b  = wb && (wb_addr == rdb_addr);
  assign rega_data = wb_hit_a ? wb_data : regs_q[rda_addr];
  assign regb_data = wb_hit_b ? wb_data : regs_q[rdb_addr];

  // A writeback landing this cycle is forwarded, so it cancels the hazard.
  assign hit_a    = rda_en && pend_q[rda_addr] && !wb_hit_a;
  assign hit_b    = rdb_en && pend_q[rdb_addr] && !wb_hit_b;
  assign id_stall = (hit_a || hit_b) && !flush;
  assign pending  = pend_q;

  assign iss_set = iss_valid && iss_wb && !id_stall;

  always_comb begin
    regs_d = regs_q;
    if (wb) regs_d[wb_addr] = wb_data;
  end

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREGS; i++) begin
      if (flush)                                 pend_d[i] = 1'b0;
      else if (iss_set && iss_addr == AW'(i))    pend_d[i] = 1'b1;
      else if (wb && wb_addr == AW'(i))          pend_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_core_regfile.sv
// Directed bench for core_regfile: stimulus queues expected outputs tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_core_regfile;
  logic        clk = 1'b0;
  logic        rst, wb, rda_en, rdb_en, iss_valid, iss_wb, flush;
  logic [3:0]  wb_addr, rda_addr, rdb_addr, iss_addr;
  logic [31:0] wb_data, rega_data, regb_data;
  logic        id_stall;
  logic [15:0] pending;

  core_regfile #(.NREGS(16), .DW(32)) dut (
    .clk(clk), .rst(rst), .wb(wb), .wb_addr(wb_addr), .wb_data(wb_data),
    .rda_en(rda_en), .rda_addr(rda_addr), .rega_data(rega_data),
    .rdb_en(rdb_en), .rdb_addr(rdb_addr), .regb_data(regb_data),
    .iss_valid(iss_valid), .iss_wb(iss_wb), .iss_addr(iss_addr),
    .flush(flush), .id_stall(id_stall), .pending(pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int { K_A, K_B, K_S, K_P } kind_t;
  typedef struct {
    string       name;
    int          cyc;
    kind_t       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic push(input string name, input kind_t k, input logic [31:0] v);
    exp_t e;
    e.name = name; e.cyc = cyc; e.kind = k; e.exp = v;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e = sbq.pop_front();
      case (e.kind)
        K_A:     act = rega_data;
        K_B:     act = regb_data;
        K_S:     act = {31'd0, id_stall};
        default: act = {16'd0, pending};
      endcase
      n_chk++;
      if (e.cyc != cyc)
        $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      else if (act !== e.exp)
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
      else
        n_pass++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; wb = 1; wb_addr = 3; wb_data = 32'hDEAD;
    rda_en = 0; rda_addr = 3; rdb_en = 0; rdb_addr = 0;
    iss_valid = 0; iss_wb = 0; iss_addr = 0; flush = 0;

    // reset with a writeback presented: must be discarded
    step(); push("rst_pend", K_P, 0); push("rst_stall", K_S, 0);
    push("rst_bypass", K_A, 32'hDEAD);
    step(); push("rst_pend2", K_P, 0);
    step(); rst = 1; wb = 0;
    push("rst_reg3", K_A, 0); push("rst_pend3", K_P, 0); push("rst_stall3", K_S, 0);

    // write then read
    step(); wb = 1; wb_addr = 5; wb_data = 32'h12345678; rda_addr = 0; rdb_addr = 5;
    push("wr_bypass_b", K_B, 32'h12345678); push("wr_reg0", K_A, 0);
    step(); wb = 0; rda_addr = 5;
    push("rd_store_a", K_A, 32'h12345678); push("rd_store_b", K_B, 32'h12345678);

    // RAW stall on port A, resolved by same-cycle writeback
    step(); iss_valid = 1; iss_wb = 1; iss_addr = 7;
    push("raw_iss_stall", K_S, 0); push("raw_iss_pend", K_P, 0);
    step(); iss_valid = 0; rda_en = 1; rda_addr = 7;
    push("raw_stall", K_S, 1); push("raw_pend7", K_P, 16'h0080);
    step(); wb = 1; wb_addr = 7; wb_data = 32'hA5A5A5A5;
    push("raw_wb_nostall", K_S, 0); push("raw_wb_bypass", K_A, 32'hA5A5A5A5);
    step(); wb = 0; rda_en = 0;
    push("raw_clear", K_P, 0); push("raw_store", K_A, 32'hA5A5A5A5);

    // port B stall, then same-index set/clear
    step(); iss_valid = 1; iss_wb = 1; iss_addr = 2;
    step(); iss_valid = 0; rdb_en = 1; rdb_addr = 2;
    push("b_stall", K_S, 1); push("b_pend2", K_P, 16'h0004);
    step(); wb = 1; wb_addr = 2; wb_data = 32'h0BADF00D; iss_valid = 1; iss_addr = 2;
    push("setclr_nostall", K_S, 0); push("setclr_bypass", K_B, 32'h0BADF00D);
    step(); wb = 0; iss_valid = 0; rdb_en = 0;
    push("setclr_pend", K_P, 16'h0004); push("setclr_reg2", K_B, 32'h0BADF00D);

    // build 0x0086, then flush
    step(); iss_valid = 1; iss_addr = 7;
    step(); iss_addr = 1; push("fl_pend84", K_P, 16'h0084);
    step(); iss_valid = 0; rdb_en = 1; rdb_addr = 1;
    push("fl_pre_stall", K_S, 1); push("fl_pend86", K_P, 16'h0086);
    step(); flush = 1;
    push("fl_nostall", K_S, 0);
    step(); flush = 0; rdb_en = 0; rda_addr = 5; rdb_addr = 7;
    push("fl_pend0", K_P, 0); push("fl_reg5", K_A, 32'h12345678);
    push("fl_reg7", K_B, 32'hA5A5A5A5);

    // blocked issue while stalled; issue without writeback
    step(); iss_valid = 1; iss_wb = 1; iss_addr = 4;
    step(); iss_valid = 0; rda_en = 1; rda_addr = 4;
    push("blk_stall", K_S, 1); push("blk_pend4", K_P, 16'h0010);
    step(); iss_valid = 1; iss_addr = 9;
    push("blk_stall2", K_S, 1);
    step(); iss_valid = 1; iss_wb = 0; iss_addr = 11; rda_en = 0;
    push("blk_pend9", K_P, 16'h0010);
    step(); iss_valid = 0; wb = 1; wb_addr = 12; wb_data = 32'hC0FFEE00;
    push("nowb_pend", K_P, 16'h0010);
    step(); wb = 0; rda_addr = 12;
    push("np_wb_pend", K_P, 16'h0010); push("np_wb_reg12", K_A, 32'hC0FFEE00);

    // reset mid-operation discards write and issue
    step(); rst = 0; wb = 1; wb_addr = 5; wb_data = 32'hFFFFFFFF;
    iss_valid = 1; iss_wb = 1; iss_addr = 6;
    step(); rst = 1; wb = 0; iss_valid = 0; rda_addr = 5;
    push("midrst_pend", K_P, 0); push("midrst_reg5", K_A, 0);

    step(); step();
    if (sbq.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d entries expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
